// File: rtl/score_pkg.sv
// Shared definitions for the score tracker slice.
// Holds the FSM state type, default widths and the RAM depth helper.
package score_pkg;

    localparam int unsigned SCORE_W_DEF = 7;
    localparam int unsigned ID_W_DEF    = 3;
    localparam int unsigned ADDR_W_DEF  = 5;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_WAIT,
        ST_CATCH,
        ST_COMPARE,
        ST_WRITE,
        ST_GLOBAL,
        ST_UPDATE,
        ST_DONE
    } state_t;

    // Number of RAM entries addressed by an addr_w-bit address.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/score_cmp.sv
// Score comparator applying the tie policy.
// Ports:
//   a   - candidate score
//   b   - reference score (stored personal best or global best)
//   win - a beats b: a > b, or a >= b when TIE_WINS is non-zero
module score_cmp
    import score_pkg::*;
#(
    parameter int unsigned SCORE_W  = SCORE_W_DEF,
    parameter int          TIE_WINS = 0
) (
    input  logic [SCORE_W-1:0] a,
    input  logic [SCORE_W-1:0] b,
    output logic               win
);

    always_comb begin
        win = (TIE_WINS != 0) ? (a >= b) : (a > b);
    end

endmodule

// File: rtl/score_tracker_p.sv
// Score tracker: per-player personal bests in external single-port RAM plus
// a running global best (score and player ID).
// Ports:
//   clk, rst             - clock, synchronous active-low reset
//   score_req/req_ready  - submission handshake (ready only in IDLE)
//   score/player_id      - submitted score and player
//   is_guest             - guest submission: no RAM access, never updates best
//   clear_req            - re-initialise RAM and global best (IDLE only)
//   ram_*                - single-port RAM interface, registered outputs
//   valid                - one-cycle result strobe
//   personal_best        - result flag: new personal best written
//   global_best          - result flag: submission beat the global best
//   best_score/best_id   - current global best
module score_tracker_p
    import score_pkg::*;
#(
    parameter int unsigned SCORE_W  = SCORE_W_DEF,
    parameter int unsigned ID_W     = ID_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RAM_LAT  = 2,
    parameter int          TIE_WINS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_req,
    output logic               req_ready,
    input  logic [SCORE_W-1:0] score,
    input  logic [ID_W-1:0]    player_id,
    input  logic               is_guest,
    input  logic               clear_req,
    input  logic [SCORE_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [SCORE_W-1:0] ram_wdata,
    output logic               ram_we,
    output logic               ram_re,
    output logic               valid,
    output logic               personal_best,
    output logic               global_best,
    output logic [SCORE_W-1:0] best_score,
    output logic [ID_W-1:0]    best_id
);

    localparam int unsigned DEPTH  = depth_of(ADDR_W);
    localparam int unsigned WCNT_W = $clog2(RAM_LAT + 1);

    state_t             state;
    logic [ADDR_W-1:0]  init_cnt;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [SCORE_W-1:0] s_q;
    logic [SCORE_W-1:0] stored_q;
    logic [ID_W-1:0]    id_q;
    logic               guest_q;
    logic [SCORE_W-1:0] cmp_ref;
    logic               cmp_win;

    // One comparator serves both decisions; the reference is chosen by state.
    always_comb begin
        cmp_ref = (state == ST_COMPARE) ? stored_q : best_score;
    end

    score_cmp #(
        .SCORE_W  (SCORE_W),
        .TIE_WINS (TIE_WINS)
    ) u_cmp (
        .a   (s_q),
        .b   (cmp_ref),
        .win (cmp_win)
    );

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_INIT;
            init_cnt      <= '0;
            wait_cnt      <= '0;
            s_q           <= '0;
            stored_q      <= '0;
            id_q          <= '0;
            guest_q       <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_we        <= 1'b0;
            ram_re        <= 1'b0;
            valid         <= 1'b0;
            personal_best <= 1'b0;
            global_best   <= 1'b0;
            best_score    <= '0;
            best_id       <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    ram_we     <= 1'b1;
                    ram_re     <= 1'b0;
                    ram_wdata  <= '0;
                    ram_addr   <= init_cnt;
                    init_cnt   <= init_cnt + 1'b1;
                    best_score <= '0;
                    best_id    <= '0;
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    ram_we <= 1'b0;
                    ram_re <= 1'b0;
                    if (clear_req) begin
                        init_cnt   <= '0;
                        best_score <= '0;
                        best_id    <= '0;
                        state      <= ST_INIT;
                    end else if (score_req) begin
                        s_q           <= score;
                        id_q          <= player_id;
                        guest_q       <= is_guest;
                        personal_best <= 1'b0;
                        global_best   <= 1'b0;
                        state         <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state <= guest_q ? ST_GLOBAL : ST_FETCH;
                end
                ST_FETCH: begin
                    ram_addr <= ADDR_W'(id_q);
                    ram_re   <= 1'b1;
                    wait_cnt <= WCNT_W'(1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == WCNT_W'(RAM_LAT)) begin
                        state <= ST_CATCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CATCH: begin
                    stored_q <= ram_rdata;
                    ram_re   <= 1'b0;
                    state    <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (cmp_win) begin
                        personal_best <= 1'b1;
                        state         <= ST_WRITE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    ram_we    <= 1'b1;
                    ram_wdata <= s_q;
                    state     <= ST_GLOBAL;
                end
                ST_GLOBAL: begin
                    ram_we <= 1'b0;
                    if (cmp_win) begin
                        global_best <= 1'b1;
                        state       <= ST_UPDATE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_UPDATE: begin
                    if (!guest_q) begin
                        best_score <= s_q;
                        best_id    <= id_q;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    valid <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    ram_re <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_tracker_p.sv
// Self-checking bench for score_tracker_p: two instances (TIE_WINS 0 and 1)
// share stimulus, each with its own RAM model and reference model.
module tb_score_tracker_p;

    localparam int SW  = 7;
    localparam int IW  = 3;
    localparam int AW  = 5;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          score_req = 1'b0;
    logic          clear_req = 1'b0;
    logic          is_guest  = 1'b0;
    logic [SW-1:0] score     = '0;
    logic [IW-1:0] player_id = '0;

    logic [1:0]          req_ready, ram_we, ram_re, valid, personal_best, global_best;
    logic [1:0][AW-1:0]  ram_addr;
    logic [1:0][SW-1:0]  ram_wdata, best_score, pipe0, pipe1;
    logic [1:0][IW-1:0]  best_id;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        score_tracker_p #(
            .SCORE_W  (SW),
            .ID_W     (IW),
            .ADDR_W   (AW),
            .RAM_LAT  (LAT),
            .TIE_WINS (g)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .score_req     (score_req),
            .req_ready     (req_ready[g]),
            .score         (score),
            .player_id     (player_id),
            .is_guest      (is_guest),
            .clear_req     (clear_req),
            .ram_rdata     (pipe1[g]),
            .ram_addr      (ram_addr[g]),
            .ram_wdata     (ram_wdata[g]),
            .ram_we        (ram_we[g]),
            .ram_re        (ram_re[g]),
            .valid         (valid[g]),
            .personal_best (personal_best[g]),
            .global_best   (global_best[g]),
            .best_score    (best_score[g]),
            .best_id       (best_id[g])
        );
    end

    // Standalone comparators for boundary checks.
    logic [SW-1:0] ca = '0, cb = '0;
    logic          cw0, cw1;
    score_cmp #(.SCORE_W(SW), .TIE_WINS(0)) u_cmp0 (.a(ca), .b(cb), .win(cw0));
    score_cmp #(.SCORE_W(SW), .TIE_WINS(1)) u_cmp1 (.a(ca), .b(cb), .win(cw1));

    // RAM models: junk-filled at start, read data delayed LAT cycles.
    logic [SW-1:0] mem [2][32];
    bit junk_done = 1'b0;
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!junk_done) begin
                for (int i = 0; i < 32; i++) mem[g][i] <= SW'($urandom);
            end else if (ram_we[g]) begin
                mem[g][ram_addr[g]] <= ram_wdata[g];
            end
            pipe0[g] <= ram_re[g] ? mem[g][ram_addr[g]] : 7'h5A;
            pipe1[g] <= pipe0[g];
        end
        junk_done <= 1'b1;
    end

    // RAM traffic monitor.
    int unsigned   we_tot[2], re_tot[2], both_tot;
    logic [AW-1:0] last_waddr[2], last_raddr[2];
    logic [SW-1:0] last_wdata[2];
    initial begin
        we_tot = '{0, 0};
        re_tot = '{0, 0};
        both_tot = 0;
    end
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_we[g]) begin
                we_tot[g]     <= we_tot[g] + 1;
                last_waddr[g] <= ram_addr[g];
                last_wdata[g] <= ram_wdata[g];
            end
            if (ram_re[g]) begin
                re_tot[g]     <= re_tot[g] + 1;
                last_raddr[g] <= ram_addr[g];
            end
        end
        if ((ram_we & ram_re) != 2'b00) both_tot <= both_tot + 1;
    end

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: personal bests and global best per instance (t = tie policy).
    int pbm[2][8];
    int bestm[2], bidm[2];

    function automatic bit beats(input int t, input int a, input int b);
        return (t == 1) ? (a >= b) : (a > b);
    endfunction

    task automatic model_clear();
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 8; i++) pbm[t][i] = 0;
            bestm[t] = 0;
            bidm[t]  = 0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("%s_valid%0d", tag, t), 32'(valid[t]), 0);
            chk($sformatf("%s_pb%0d", tag, t), 32'(personal_best[t]), 0);
            chk($sformatf("%s_gb%0d", tag, t), 32'(global_best[t]), 0);
            chk($sformatf("%s_we%0d", tag, t), 32'(ram_we[t]), 0);
            chk($sformatf("%s_re%0d", tag, t), 32'(ram_re[t]), 0);
            chk($sformatf("%s_addr%0d", tag, t), 32'(ram_addr[t]), 0);
            chk($sformatf("%s_wdata%0d", tag, t), 32'(ram_wdata[t]), 0);
            chk($sformatf("%s_bscore%0d", tag, t), 32'(best_score[t]), 0);
            chk($sformatf("%s_bid%0d", tag, t), 32'(best_id[t]), 0);
            chk($sformatf("%s_ready%0d", tag, t), 32'(req_ready[t]), 0);
        end
    endtask

    // Follows an INIT sweep until both instances are idle with no write pending.
    task automatic check_init(input string tag);
        int wecnt[2];
        bit bad[2];
        int nval = 0;
        int cyc  = 0;
        wecnt = '{0, 0};
        bad   = '{1'b0, 1'b0};
        while (!(req_ready == 2'b11 && ram_we == 2'b00) && cyc < 60) begin
            for (int t = 0; t < 2; t++) begin
                if (ram_we[t]) begin
                    if (ram_addr[t] != AW'(wecnt[t]) || ram_wdata[t] != '0) bad[t] = 1'b1;
                    wecnt[t]++;
                end
                if (ram_re[t]) bad[t] = 1'b1;
                if (valid[t]) nval++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("%s_wecount%0d", tag, t), 32'(wecnt[t]), 32);
            chk($sformatf("%s_seq%0d", tag, t), 32'(bad[t]), 0);
            chk($sformatf("%s_bscore%0d", tag, t), 32'(best_score[t]), 0);
            chk($sformatf("%s_bid%0d", tag, t), 32'(best_id[t]), 0);
            chk($sformatf("%s_ready%0d", tag, t), 32'(req_ready[t]), 1);
        end
        chk($sformatf("%s_novalid", tag), 32'(nval), 0);
        model_clear();
    endtask

    task automatic run_txn(input int sc, input int id, input bit guest, input bit poke);
        int exp_lat[2], got[2];
        bit epb[2], egb[2];
        int unsigned we0[2], re0[2], both0;
        int cyc;
        for (int t = 0; t < 2; t++) begin
            if (guest) begin
                epb[t] = 1'b0;
                egb[t] = beats(t, sc, bestm[t]);
                exp_lat[t] = egb[t] ? 4 : 3;
            end else begin
                epb[t] = beats(t, sc, pbm[t][id]);
                egb[t] = epb[t] && beats(t, sc, bestm[t]);
                exp_lat[t] = !epb[t] ? 5 + LAT : (egb[t] ? 8 + LAT : 7 + LAT);
                if (epb[t]) pbm[t][id] = sc;
                if (egb[t]) begin
                    bestm[t] = sc;
                    bidm[t]  = id;
                end
            end
            we0[t] = we_tot[t];
            re0[t] = re_tot[t];
            got[t] = -1;
        end
        both0 = both_tot;

        score     = SW'(sc);
        player_id = IW'(id);
        is_guest  = guest;
        score_req = 1'b1;
        @(posedge clk); #1;
        score_req = 1'b0;
        cyc = 0;
        while ((got[0] < 0 || got[1] < 0) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 2) begin
                score_req = 1'b1;
                score     = SW'($urandom);
                player_id = IW'($urandom);
                is_guest  = 1'($urandom);
            end else if (poke && cyc == 3) begin
                score_req = 1'b0;
            end
            for (int t = 0; t < 2; t++) begin
                if (got[t] < 0 && valid[t]) begin
                    got[t] = cyc;
                    chk($sformatf("pb%0d_s%0d_id%0d", t, sc, id), 32'(personal_best[t]), 32'(epb[t]));
                    chk($sformatf("gb%0d_s%0d_id%0d", t, sc, id), 32'(global_best[t]), 32'(egb[t]));
                    chk($sformatf("bscore%0d_s%0d", t, sc), 32'(best_score[t]), 32'(bestm[t]));
                    chk($sformatf("bid%0d_s%0d", t, sc), 32'(best_id[t]), 32'(bidm[t]));
                end
            end
        end
        score_req = 1'b0;
        @(posedge clk); #1;
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("latency%0d_s%0d_id%0d_g%0d", t, sc, id, guest), 32'(got[t]), 32'(exp_lat[t]));
            chk($sformatf("valid_once%0d", t), 32'(valid[t]), 0);
            chk($sformatf("pb_hold%0d", t), 32'(personal_best[t]), 32'(epb[t]));
            chk($sformatf("gb_hold%0d", t), 32'(global_best[t]), 32'(egb[t]));
            chk($sformatf("we_cycles%0d", t), we_tot[t] - we0[t], epb[t] ? 1 : 0);
            chk($sformatf("re_cycles%0d", t), re_tot[t] - re0[t], guest ? 0 : LAT + 1);
            if (epb[t]) begin
                chk($sformatf("waddr%0d", t), 32'(last_waddr[t]), 32'(id));
                chk($sformatf("wdata%0d", t), 32'(last_wdata[t]), 32'(sc));
            end
            if (!guest) chk($sformatf("raddr%0d", t), 32'(last_raddr[t]), 32'(id));
        end
        chk("re_we_exclusive", both_tot - both0, 0);
    endtask

    task automatic random_txns(input int n);
        int id, sc, r;
        bit guest;
        for (int i = 0; i < n; i++) begin
            id    = $urandom_range(0, 7);
            guest = ($urandom_range(0, 4) == 0);
            r     = $urandom_range(0, 9);
            if (r < 2)      sc = bestm[0];
            else if (r < 4) sc = pbm[0][id];
            else if (r == 4) sc = 0;
            else            sc = $urandom_range(0, 127);
            run_txn(sc, id, guest, (i % 7) == 3);
        end
    endtask

    initial begin
        int pa[7], pb[7];
        pa = '{0, 127, 0, 127, 64, 63, 50};
        pb = '{0, 127, 127, 0, 63, 64, 50};

        // Comparator boundaries: zero, max, equal, adjacent, then random.
        for (int i = 0; i < 13; i++) begin
            if (i < 7) begin
                ca = SW'(pa[i]);
                cb = SW'(pb[i]);
            end else begin
                ca = SW'($urandom);
                cb = SW'($urandom);
            end
            #1;
            chk($sformatf("cmp0_%0d_%0d", ca, cb), 32'(cw0), 32'(ca > cb));
            chk($sformatf("cmp1_%0d_%0d", ca, cb), 32'(cw1), 32'(ca >= cb));
        end

        // Reset and initial sweep.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        check_init("init");

        // Directed sequence.
        run_txn(50, 3, 1'b0, 1'b0);
        run_txn(40, 5, 1'b0, 1'b0);
        run_txn(30, 3, 1'b0, 1'b0);
        run_txn(50, 5, 1'b0, 1'b1);
        run_txn(100, 0, 1'b1, 1'b0);
        run_txn(0, 1, 1'b1, 1'b1);
        run_txn(0, 6, 1'b0, 1'b0);

        random_txns(40);

        // Clear together with a request: clear wins, request dropped.
        clear_req = 1'b1;
        score_req = 1'b1;
        score     = SW'(120);
        player_id = IW'(2);
        is_guest  = 1'b0;
        @(posedge clk); #1;
        clear_req = 1'b0;
        score_req = 1'b0;
        chk("clear_ready0", 32'(req_ready[0]), 0);
        chk("clear_ready1", 32'(req_ready[1]), 0);
        check_init("clear");

        random_txns(10);

        // Reset while a read is waiting on the RAM.
        score     = SW'(20);
        player_id = IW'(2);
        is_guest  = 1'b0;
        score_req = 1'b1;
        @(posedge clk); #1;
        score_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_re_active", 32'(ram_re), 32'(2'b11));
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("abort");
        rst = 1'b1;
        check_init("reinit");

        random_txns(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_tracker_p.md
Name: score_tracker_p

Overview:
- Parametrised successor to the game's fixed-width score tracker.
- On each accepted score submission it:
  - reads the player's stored personal best from external single-port RAM;
  - writes back the new score if it beats the stored best;
  - compares the score against a running global best, which is exposed as score plus player ID.
- Adds, relative to the previous generation:
  - a ready/valid request handshake;
  - a tie policy;
  - run-time clear (RAM re-initialisation);
  - parametrised RAM read latency, widths and depth.

Parameters:
- SCORE_W, 7, score and RAM data width.
- ID_W, 3, player ID width; must satisfy ID_W <= ADDR_W.
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W.
- RAM_LAT, 2, wait cycles between read issue and data capture; must be >= 1.
- TIE_WINS, 0, 0 = strictly greater wins; 1 = greater-or-equal wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- score_req  in  1  submission strobe
- req_ready  out  1  high only in IDLE
- score  in  SCORE_W  submitted score
- player_id  in  ID_W  submitting player
- is_guest  in  1  guest submission; no RAM access, never updates global best
- clear_req  in  1  re-init RAM and global best; honoured in IDLE only
- ram_rdata  in  SCORE_W  RAM read data
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  SCORE_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- valid  out  1  one-cycle result strobe
- personal_best  out  1  result flag
- global_best  out  1  result flag
- best_score  out  SCORE_W  current global best score
- best_id  out  ID_W  current global best player

Behaviour:
- Reset (rst=0 at posedge), which also aborts any operation in flight:
  - outputs: valid, personal_best, global_best, ram_we, ram_re = 0; best_score = 0; best_id = 0; ram_addr = 0; ram_wdata = 0;
  - internal: init counter = 0; FSM -> INIT.
- States: INIT, IDLE, CHECK, FETCH, WAIT, CATCH, COMPARE, WRITE, GLOBAL, UPDATE, DONE. Unreachable encodings -> IDLE.
- INIT:
  - drives ram_we=1, ram_re=0, ram_wdata=0, ram_addr=counter;
  - counter increments each cycle, covering addresses 0..DEPTH-1 in DEPTH cycles; after the last address -> IDLE.
  - best_score and best_id are held at 0.
- IDLE:
  - req_ready=1, ram_we=0, ram_re=0.
  - clear_req=1 -> INIT, clearing best_score and best_id; clear wins over a simultaneous score_req.
  - Otherwise score_req=1 accepts the request: latches score, player_id and is_guest; clears personal_best and global_best -> CHECK.
- CHECK: guest -> GLOBAL; member -> FETCH.
- FETCH: ram_addr = zero-extended player_id, ram_re=1 -> WAIT.
- WAIT: ram_re stays 1 for RAM_LAT cycles -> CATCH.
- CATCH: capture ram_rdata -> COMPARE. ram_re drops on leaving CATCH.
- COMPARE (wins = s > stored, or s >= stored if TIE_WINS):
  - win: personal_best=1 -> WRITE;
  - else -> DONE.
- WRITE: one cycle with ram_we=1, ram_wdata=s, same address -> GLOBAL.
- GLOBAL (same win rule vs best_score):
  - win: global_best=1 -> UPDATE;
  - else -> DONE.
- UPDATE: if member, best_score=s and best_id=player_id; guests leave both unchanged -> DONE.
- DONE: valid=1 for exactly one cycle -> IDLE.
  - personal_best and global_best hold until the next accept or reset.
- Latency, counted from the accepting edge to the cycle valid is high, with L=RAM_LAT:
  - member, no personal best: 5+L;
  - member, personal best but not global: 7+L;
  - member, both: 8+L;
  - guest, not global: 3;
  - guest, global: 4.
- Requests are never queued. score_req while req_ready=0 is ignored.
- Width rules: unsigned compare; no arithmetic overflow is possible. Score 0 never wins under TIE_WINS=0 against a cleared entry.
- RAM contract: ram_re and ram_we are never high in the same cycle.

Decomposition:
- Package score_pkg holds:
  - state enum;
  - default width constants (SCORE_W_DEF, ID_W_DEF, ADDR_W_DEF);
  - localparam DEPTH helper.
- One sub-module is natural: score_cmp (parametrised SCORE_W and TIE_WINS).
  - Shared by the COMPARE and GLOBAL decisions.
  - Bench checks it standalone at boundaries 0, max and equal.

Test Plan:
- Reset then idle: after reset, exactly 32 ram_we cycles on addresses 0..31 with data 0, then req_ready=1; best_score=0, best_id=0.
- Member first score (id=3, score=50, RAM returns 0 after RAM_LAT=2):
  - ram_re on addr 3, then ram_we addr 3 data 50;
  - valid at cycle 10 with personal_best=1, global_best=1;
  - best_score=50, best_id=3.
- Second member lower score (id=5, score=40, stored 0):
  - personal_best=1, global_best=0, valid at cycle 9;
  - then id=3 score=30 (stored 50): personal_best=0, no write, valid at cycle 7.
- Tie policy (id=5 score=50 vs best 50):
  - TIE_WINS=0: global_best=0;
  - TIE_WINS=1: global_best=1, best_id=5.
- Guest score=100 with best 50:
  - no RAM activity, global_best=1, valid at cycle 4;
  - best_score stays 50.
- Abort and handshake:
  - clear_req with score_req together in IDLE: INIT runs, request dropped, best cleared.
  - rst=0 during WAIT: all outputs at reset values next cycle, INIT restarts.
  - score_req while busy: ignored.
